serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial N-bit subtractor computing D = A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the combinational ripple-carry adders in the lab datapath. It trades latency for area and exposes a start/busy/done handshake to the lab calculator control logic.

## Interface
- WIDTH, default 4: operand and result width in bits; legal range 2..16.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request to begin a subtraction; sampled on the rising edge of clk.
- a  in  WIDTH  minuend; unsigned; sampled only when start is accepted.
- b  in  WIDTH  subtrahend; unsigned; sampled only when start is accepted.
- bin  in  1  borrow-in; sampled only when start is accepted.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse when d and bout become valid.
- d  out  WIDTH  difference; holds its value until the next completion.
- bout  out  1  borrow-out; 1 means A < B + Bin as unsigned values.

## Operation
- The state machine has three states: IDLE, SHIFT and DONE. It resets to IDLE.
- **Start acceptance:** start is accepted only in IDLE or DONE.
  - On acceptance, a and b load into shift registers SA and SB, bin loads into the borrow register BR, bit counter CNT is cleared, and the state goes to SHIFT.
  - start is ignored while in SHIFT. The a, b and bin inputs are don't-care outside the accept edge.
- **SHIFT state, each edge:**
  - Difference bit = SA[0] ^ SB[0] ^ BR.
  - Next BR = (~SA[0] & SB[0]) | (~(SA[0] ^ SB[0]) & BR).
  - The difference bit shifts into the MSB of accumulator R. SA and SB shift right. CNT increments.
- **End of SHIFT:** on the edge where CNT == WIDTH−1, the state goes to DONE.
  - On that same edge, d is loaded with the completed accumulator value (including that edge's bit), and bout is loaded with that edge's next-BR value.
- **DONE state:**
  - It lasts one cycle and returns to IDLE unless start is accepted.
  - If start is accepted in DONE, the state goes directly to SHIFT, giving back-to-back operation with no idle gap.
- **Outputs:** busy = (state == SHIFT) and done = (state == DONE), both decoded from state.
- **Result stability:** d and bout change only on completion edges. Internal shifting is never visible on d.
- **Reset values:** d = 0, bout = 0, busy = 0, done = 0; SA, SB, R, BR and CNT are all 0.
- **Reset mid-operation:** asserting reset at any point immediately forces all outputs and state to their reset values. The interrupted operation is discarded. The first start accepted after reset is processed normally.

## Timing
- Take the start accept edge as E.
- busy is high from edge E to edge E+WIDTH, i.e. WIDTH cycles.
- done is high from edge E+WIDTH to edge E+WIDTH+1.
- d and bout update at edge E+WIDTH.
- Latency from the accept edge to valid result is WIDTH cycles.
- The maximum issue rate is one operation per WIDTH+1 cycles (start accepted in DONE).
- No combinational path exists from any input to any output.

## Configuration
- **Macro SERSUB_SAT_EN defined:** unsigned saturating subtract.
  - At completion, if the final borrow is 1, d is loaded with 0 instead of the accumulator.
  - bout still reports 1, so underflow remains visible.
- **Macro not defined:** d is the wrapped modulo-2^WIDTH difference, i.e. the two's-complement wrap.
- Timing, handshake and reset behaviour are identical in both builds.

## Test plan
All scenarios use WIDTH=4.
1. **Reset:** assert reset asynchronously between clock edges → d=0, bout=0, busy=0 and done=0 immediately, with no edge required.
2. **No borrow:** start with a=9, b=3, bin=0 → busy high for 4 cycles; done pulses at edge E+4 with d=6, bout=0; d holds 6 afterwards.
3. **Underflow:** start with a=3, b=9, bin=0 → d=10, bout=1; with SERSUB_SAT_EN, d=0, bout=1.
4. **Borrow-in ripple:** start with a=0, b=0, bin=1 → d=15, bout=1; with SERSUB_SAT_EN, d=0, bout=1.
5. **Start while busy, then back-to-back:**
   - Start a=12, b=5, then pulse start with a=1, b=1 during SHIFT → the second start is ignored; done at E+4 with d=7, bout=0.
   - Then start a=8, b=8 in the DONE cycle → busy rises with no idle gap; the next done gives d=0, bout=0.
6. **Reset mid-operation:** start a=15, b=1, then assert reset two cycles later → all outputs return to 0 with no done pulse. After release, start a=6, b=2 → d=4, bout=0 after 4 cycles.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side issues start/a/b/bin; the slave side returns busy/done/d/bout.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    modport master (output start, a, b, bin, input busy, done, d, bout);
    modport slave  (input start, a, b, bin, output busy, done, d, bout);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B - Bin, LSB first, through one full-subtractor cell and a borrow flop.
// Optional macro SERSUB_SAT_EN: clamp d to 0 on underflow (bout still reports the borrow).
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] sa_reg;
    logic [WIDTH-1:0] sb_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_reg;
    logic             br_reg;
    logic             bout_reg;
    logic [CW-1:0]    cnt_reg;

    logic             accept;
    logic             last_bit;
    logic             diff_bit;
    logic             br_next;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] d_next;

    assign accept   = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    // Full-subtractor cell operating on the current LSBs and the stored borrow.
    assign diff_bit = sa_reg[0] ^ sb_reg[0] ^ br_reg;
    assign br_next  = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & br_reg);
    assign r_next   = {diff_bit, r_reg[WIDTH-1:1]};

`ifdef SERSUB_SAT_EN
    assign d_next = br_next ? '0 : r_next;
`else
    assign d_next = r_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = accept ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // R needs no clear on accept: all WIDTH bits are overwritten before d samples it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa_reg   <= '0;
            sb_reg   <= '0;
            r_reg    <= '0;
            br_reg   <= 1'b0;
            cnt_reg  <= '0;
            d_reg    <= '0;
            bout_reg <= 1'b0;
        end else if (accept) begin
            sa_reg  <= bus.a;
            sb_reg  <= bus.b;
            br_reg  <= bus.bin;
            cnt_reg <= '0;
        end else if (state_reg == SHIFT) begin
            sa_reg  <= sa_reg >> 1;
            sb_reg  <= sb_reg >> 1;
            r_reg   <= r_next;
            br_reg  <= br_next;
            cnt_reg <= cnt_reg + CW'(1);
            if (last_bit) begin
                d_reg    <= d_next;
                bout_reg <= br_next;
            end
        end
    end

    assign bus.busy = (state_reg == SHIFT);
    assign bus.done = (state_reg == DONE);
    assign bus.d    = d_reg;
    assign bus.bout = bout_reg;
endmodule
